tc_alarm: RTL and testbench

Compare/alarm unit that consumes the 32-bit free-running count produced by the `tc` timer and raises an interrupt when the count reaches a software-programmed value. It supports one-shot and periodic (auto-reload) modes. Software controls it through its own Wishbone slave register window. It sits directly downstream of `tc`, sharing its clock and reset, and drives one CPU interrupt line.

---
 rtl/tc_pkg.sv | 21 ++
 rtl/tc_alarm_if.sv | 17 +
 rtl/tc_alarm_regs.sv | 62 ++++++
 rtl/tc_alarm.sv | 71 +++++++
 tb/tb_tc_alarm.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tc_pkg.sv
// tc_pkg: shared register offsets, bit indices and reset constants for the tc timer family
package tc_pkg;
    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_STATUS = 5'h04;
    localparam logic [4:0] OFF_CMP    = 5'h08;
    localparam logic [4:0] OFF_PERIOD = 5'h0C;
    localparam logic [4:0] OFF_TIME   = 5'h10;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IE       = 2;
    localparam int ST_PEND       = 0;
    localparam int ST_MISSED     = 1;
    localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/tc_alarm_if.sv
// tc_alarm_if: Wishbone classic bus bundle for the tc_alarm register window
interface tc_alarm_if #(parameter int AW = 17);
    logic [AW-1:0] adr;
    logic [31:0]   dat_i;
    logic [31:0]   dat_o;
    logic [3:0]    sel;
    logic          we;
    logic          cyc;
    logic          stb;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack;
    logic          err;
    logic          rty;
    modport master (output adr, dat_i, sel, we, cyc, stb, cti, bte, input dat_o, ack, err, rty);
    modport slave  (input adr, dat_i, sel, we, cyc, stb, cti, bte, output dat_o, ack, err, rty);
endinterface

// File: rtl/tc_alarm_regs.sv
// tc_alarm_regs: Wishbone decode, byte-lane merge, read mux and single-cycle ack generation
module tc_alarm_regs
    import tc_pkg::*;
#(
    parameter int AW = 17
) (
    input  logic        clk,
    input  logic        rst,
    tc_alarm_if.slave   wb,
    input  logic [2:0]  ctrl,
    input  logic [1:0]  status,
    input  logic [31:0] cmp,
    input  logic [31:0] period,
    input  logic [31:0] tc,
    output logic        wr_ctrl,
    output logic        wr_status,
    output logic        wr_cmp,
    output logic        wr_period,
    output logic [31:0] wdata,
    output logic [1:0]  w1c
);
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d, rd;
    logic [4:0]  off;
    logic        wr;
    logic        unused_ok;

    always_comb begin
        off       = {wb.adr[4:2], 2'b00};
        ack_d     = wb.cyc & wb.stb & ~ack_q;
        wr        = ack_d & wb.we;
        rd        = off == OFF_CTRL   ? {29'd0, ctrl}   :
                    off == OFF_STATUS ? {30'd0, status} :
                    off == OFF_CMP    ? cmp             :
                    off == OFF_PERIOD ? period          :
                    off == OFF_TIME   ? tc              : 32'd0;
        dat_d     = ack_d ? rd : 32'd0;
        // merging against the addressed register keeps unselected lanes intact
        wdata     = merge_bytes(rd, wb.dat_i, wb.sel);
        w1c       = wb.sel[0] ? wb.dat_i[1:0] : 2'b00;
        wr_ctrl   = wr && off == OFF_CTRL;
        wr_status = wr && off == OFF_STATUS;
        wr_cmp    = wr && off == OFF_CMP;
        wr_period = wr && off == OFF_PERIOD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= 32'd0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    assign wb.ack    = ack_q;
    assign wb.dat_o  = dat_q;
    assign wb.err    = 1'b0;
    assign wb.rty    = 1'b0;
    assign unused_ok = ^{wb.cti, wb.bte, wb.adr[AW-1:5], wb.adr[1:0]};
endmodule

// File: rtl/tc_alarm.sv
// tc_alarm: compare/alarm unit raising a level interrupt when the tc count hits CMP
module tc_alarm
    import tc_pkg::*;
#(
    parameter int AW = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tc_i,
    tc_alarm_if.slave   wb,
    output logic        irq_o
);
    logic [2:0]  ctrl_q, ctrl_d;
    logic [1:0]  status_q, status_d;
    logic [31:0] cmp_q, cmp_d, period_q, period_d;
    logic        irq_q, irq_d;
    logic        wr_ctrl, wr_status, wr_cmp, wr_period, match;
    logic [31:0] wdata;
    logic [1:0]  w1c;

    tc_alarm_regs #(.AW(AW)) u_regs (
        .clk      (clk),
        .rst      (rst),
        .wb       (wb),
        .ctrl     (ctrl_q),
        .status   (status_q),
        .cmp      (cmp_q),
        .period   (period_q),
        .tc       (tc_i),
        .wr_ctrl  (wr_ctrl),
        .wr_status(wr_status),
        .wr_cmp   (wr_cmp),
        .wr_period(wr_period),
        .wdata    (wdata),
        .w1c      (w1c)
    );

    always_comb begin
        match    = ctrl_q[CTRL_EN] && tc_i == cmp_q;
        ctrl_d   = ctrl_q;
        if (match && !ctrl_q[CTRL_PERIODIC]) ctrl_d[CTRL_EN] = 1'b0;
        if (wr_ctrl) ctrl_d = wdata[2:0];
        // software writes override the hardware reload and one-shot clear
        cmp_d    = wr_cmp ? wdata : (match && ctrl_q[CTRL_PERIODIC]) ? cmp_q + period_q : cmp_q;
        period_d = wr_period ? wdata : period_q;
        status_d = status_q & ~(wr_status ? w1c : 2'b00);
        if (match) begin
            status_d[ST_PEND]   = 1'b1;
            status_d[ST_MISSED] = status_d[ST_MISSED] | status_q[ST_PEND];
        end
        irq_d    = status_q[ST_PEND] & ctrl_q[CTRL_IE];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= 3'd0;
            status_q <= 2'd0;
            cmp_q    <= CMP_RST;
            period_q <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            cmp_q    <= cmp_d;
            period_q <= period_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_o = irq_q;
endmodule

// File: tb/tb_tc_alarm.sv
// tb_tc_alarm: table vectors, directed corner sequences and random bus traffic against a reference model
module tb_tc_alarm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tc_i = 32'd0;
    logic        irq_o;
    int          vecs = 0;
    int          errs = 0;

    tc_alarm_if #(.AW(17)) wb();
    tc_alarm #(.AW(17)) dut (.clk(clk), .rst(rst), .tc_i(tc_i), .wb(wb), .irq_o(irq_o));

    always #5 clk = ~clk;

    bit          m_en, m_per, m_ie, m_pend, m_missed, m_irq, m_ack, m_rdack;
    logic [31:0] m_cmp = 32'hFFFF_FFFF, m_period = 32'd0, m_dat = 32'd0;

    typedef struct {
        bit          we;
        logic [4:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (tc=%h)", name, got, exp, tc_i);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input logic [2:0] i);
        case (i)
            3'd0:    return {29'd0, m_ie, m_per, m_en};
            3'd1:    return {30'd0, m_missed, m_pend};
            3'd2:    return m_cmp;
            3'd3:    return m_period;
            3'd4:    return tc_i;
            default: return 32'd0;
        endcase
    endfunction

    // one clock: predict from the rules, advance, then compare the registered outputs
    task automatic tick();
        logic        acc, hit, nen, nper, nie, npend, nmissed, nirq;
        logic [31:0] ncmp, nperiod, rd, w;
        acc = wb.cyc && wb.stb && !m_ack;
        hit = m_en && tc_i == m_cmp;
        rd = model_rd(wb.adr[4:2]);
        nen = m_en; nper = m_per; nie = m_ie; npend = m_pend; nmissed = m_missed;
        ncmp = m_cmp; nperiod = m_period;
        if (hit) begin
            nmissed = m_missed | m_pend;
            npend = 1'b1;
            if (m_per) ncmp = m_cmp + m_period;
            else nen = 1'b0;
        end
        if (acc && wb.we) begin
            case (wb.adr[4:2])
                3'd0: begin
                    w = merge({29'd0, m_ie, m_per, m_en}, wb.dat_i, wb.sel);
                    nen = w[0]; nper = w[1]; nie = w[2];
                end
                3'd1: if (wb.sel[0]) begin
                    if (wb.dat_i[0] && !hit) npend = 1'b0;
                    if (wb.dat_i[1] && !(hit && m_pend)) nmissed = 1'b0;
                end
                3'd2: ncmp = merge(m_cmp, wb.dat_i, wb.sel);
                3'd3: nperiod = merge(m_period, wb.dat_i, wb.sel);
                default: ;
            endcase
        end
        nirq = m_pend && m_ie;
        @(posedge clk);
        #1;
        if (rst) begin
            m_en = 0; m_per = 0; m_ie = 0; m_pend = 0; m_missed = 0; m_irq = 0; m_ack = 0; m_rdack = 0;
            m_cmp = 32'hFFFF_FFFF; m_period = 32'd0; m_dat = 32'd0;
        end else begin
            m_en = nen; m_per = nper; m_ie = nie; m_pend = npend; m_missed = nmissed; m_irq = nirq;
            m_cmp = ncmp; m_period = nperiod;
            m_ack = acc; m_rdack = acc && !wb.we; m_dat = acc ? rd : 32'd0;
        end
        tc_i = tc_i + 1;
        chk("irq", 32'(irq_o), 32'(m_irq));
        chk("ack", 32'(wb.ack), 32'(m_ack));
        if (m_rdack) chk("rdata", wb.dat_o, m_dat);
    endtask

    task automatic run_until(input logic [31:0] target);
        int n = 0;
        while (tc_i != target && n < 5000) begin
            tick();
            n++;
        end
        if (tc_i != target) chk("run_timeout", tc_i, target);
    endtask

    task automatic xfer(input bit we, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rdata);
        int n = 0;
        wb.adr = 17'(a); wb.dat_i = d; wb.sel = s; wb.we = we; wb.cyc = 1'b1; wb.stb = 1'b1;
        do begin
            tick();
            n++;
        end while (wb.ack !== 1'b1 && n < 4);
        if (wb.ack !== 1'b1) chk("ack_timeout", 32'(wb.ack), 32'd1);
        rdata = wb.dat_o;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        xfer(1'b1, a, d, s, dummy);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, a, 32'd0, 4'hF, r);
        chk(name, r, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        wb.adr = '0; wb.dat_i = '0; wb.sel = '0; wb.we = 0; wb.cyc = 0; wb.stb = 0; wb.cti = '0; wb.bte = '0;
        tbl[0]  = '{0, 5'h00, 32'h0,         4'h0, 32'h0000_0000};
        tbl[1]  = '{0, 5'h04, 32'h0,         4'h0, 32'h0000_0000};
        tbl[2]  = '{0, 5'h08, 32'h0,         4'h0, 32'hFFFF_FFFF};
        tbl[3]  = '{0, 5'h0C, 32'h0,         4'h0, 32'h0000_0000};
        tbl[4]  = '{1, 5'h0C, 32'hAABB_CCDD, 4'h2, 32'h0};
        tbl[5]  = '{0, 5'h0C, 32'h0,         4'h0, 32'h0000_CC00};
        tbl[6]  = '{0, 5'h18, 32'h0,         4'h0, 32'h0000_0000};
        tbl[7]  = '{1, 5'h18, 32'h1234_5678, 4'hF, 32'h0};
        tbl[8]  = '{0, 5'h18, 32'h0,         4'h0, 32'h0000_0000};
        tbl[9]  = '{0, 5'h14, 32'h0,         4'h0, 32'h0000_0000};
        tbl[10] = '{1, 5'h08, 32'h1234_5678, 4'h9, 32'h0};
        tbl[11] = '{0, 5'h08, 32'h0,         4'h0, 32'h12FF_FF78};
        tbl[12] = '{1, 5'h00, 32'hFFFF_FFF8, 4'hF, 32'h0};
        tbl[13] = '{0, 5'h00, 32'h0,         4'h0, 32'h0000_0000};
        tbl[14] = '{1, 5'h00, 32'h0000_0006, 4'hE, 32'h0};
        tbl[15] = '{0, 5'h00, 32'h0,         4'h0, 32'h0000_0000};
        tbl[16] = '{0, 5'h1C, 32'h0,         4'h0, 32'h0000_0000};
        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].we) wr(tbl[i].adr, tbl[i].dat, tbl[i].sel);
            else rd_chk($sformatf("tbl[%0d]", i), tbl[i].adr, tbl[i].exp);
        end

        // one-shot
        do_reset();
        tc_i = 32'd0;
        wr(5'h08, 32'd100, 4'hF);
        wr(5'h00, 32'h5, 4'hF);
        run_until(32'd100);
        tick();
        chk("os_irq_101", 32'(irq_o), 32'd0);
        tick();
        chk("os_irq_102", 32'(irq_o), 32'd1);
        rd_chk("os_ctrl", 5'h00, 32'h4);
        rd_chk("os_status", 5'h04, 32'h1);
        wr(5'h04, 32'h1, 4'h1);
        repeat (4) tick();
        chk("os_irq_clr", 32'(irq_o), 32'd0);
        rd_chk("os_status_clr", 5'h04, 32'h0);

        // periodic, PEND never cleared
        do_reset();
        tc_i = 32'd0;
        wr(5'h0C, 32'd20, 4'hF);
        wr(5'h08, 32'd10, 4'hF);
        wr(5'h00, 32'h7, 4'hF);
        run_until(32'd52);
        rd_chk("per_cmp", 5'h08, 32'd70);
        rd_chk("per_status", 5'h04, 32'h3);

        // wrap-around
        do_reset();
        tc_i = 32'hFFFF_FFE0;
        wr(5'h0C, 32'h20, 4'hF);
        wr(5'h08, 32'hFFFF_FFF0, 4'hF);
        wr(5'h00, 32'h7, 4'hF);
        run_until(32'hFFFF_FFF2);
        rd_chk("wrap_cmp1", 5'h08, 32'h10);
        rd_chk("wrap_st1", 5'h04, 32'h1);
        wr(5'h04, 32'h3, 4'h1);
        run_until(32'h12);
        rd_chk("wrap_st2", 5'h04, 32'h1);
        rd_chk("wrap_cmp2", 5'h08, 32'h30);

        // W1C lands on the match cycle
        do_reset();
        tc_i = 32'd0;
        wr(5'h0C, 32'd100, 4'hF);
        wr(5'h08, 32'd40, 4'hF);
        wr(5'h00, 32'h7, 4'hF);
        run_until(32'd50);
        rd_chk("cf_st0", 5'h04, 32'h1);
        run_until(32'd140);
        wr(5'h04, 32'h1, 4'h1);
        chk("cf_irq", 32'(irq_o), 32'd1);
        rd_chk("cf_st1", 5'h04, 32'h3);

        // reset mid-run while periodic with PEND set
        rst = 1'b1;
        tick();
        chk("rst_irq", 32'(irq_o), 32'd0);
        rst = 1'b0;
        rd_chk("rst_ctrl", 5'h00, 32'h0);
        rd_chk("rst_status", 5'h04, 32'h0);
        rd_chk("rst_cmp", 5'h08, 32'hFFFF_FFFF);
        rd_chk("rst_period", 5'h0C, 32'h0);
        tc_i = 32'hFFFF_FFF0;
        run_until(32'h10);
        rd_chk("rst_nomatch", 5'h04, 32'h0);

        // random traffic checked by the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 5)) tick();
            end else begin
                a = 5'($urandom_range(0, 7) << 2);
                d = $urandom;
                if (a == 5'h08) d = tc_i + $urandom_range(1, 30);
                if (a == 5'h0C) d = $urandom_range(0, 25);
                if (a == 5'h00) d = $urandom_range(0, 7);
                if (a == 5'h04) d = $urandom_range(0, 3);
                s = $urandom_range(0, 2) != 0 ? 4'hF : 4'($urandom);
                wb.cti = 3'($urandom);
                wb.bte = 2'($urandom);
                xfer(1'($urandom), a, d, s, r);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
